spi_tx_controller: RTL and testbench
====================================

Name: spi_tx_controller

Overview:
- Byte-oriented SPI master transmitter that queues bytes written over a simple strobe interface and streams them MSB-first in SPI mode 0.
- Sits between a CPU/peripheral bus (the write strobe `interrupt` plus `value`) and an external SPI slave.
- All logic runs in the `clk` domain. `spi_clk` is a slower reference input that is synchronized and edge-detected; it sets the SCK rate.

Parameters:
- DATA_W, 8, width of one SPI word and of `value`.
- FIFO_DEPTH, 8, number of TX FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- spi_clk, input, 1, SCK reference; treated as data and synchronized (2-FF) into `clk`; its frequency must be at most clk/3.
- interrupt, input, 1, write strobe; each `clk` rising edge with `interrupt`=1 pushes `value` into the FIFO.
- value, input, DATA_W, byte to transmit.
- miso, input, 1, serial data from the slave.
- mosi, output, 1, serial data to the slave, MSB first.
- ss, output, 1, slave select, active low.
- spi_clk_o, output, 1, SCK to the slave; idles low (CPOL=0, CPHA=0).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: ss=1, spi_clk_o=0, mosi=0.
  - FIFO empty, state IDLE, bit counter 0, rx register 0.
  - Reset mid-transfer aborts immediately; the partial byte and all queued bytes are lost.
- Reference edges:
  - ref_s is spi_clk after the 2-FF synchronizer.
  - ref_rise and ref_fall are one-`clk` pulses generated by comparing ref_s with its previous value.
- FIFO:
  - Push when interrupt=1 and not full.
  - A push while full is dropped silently.
  - A push and a pop in the same cycle are both honoured.
  - Consecutive-cycle pushes store consecutive bytes in order.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter of width log2(FIFO_DEPTH)+1 gives full and empty.
- State IDLE:
  - Outputs: ss=1, spi_clk_o=0, mosi=0.
  - On ref_fall with FIFO not empty: pop the head byte into the shift register, set ss=0, mosi=bit[DATA_W-1], bitcnt=0, go to SHIFT.
- State SHIFT:
  - On ref_rise: spi_clk_o=1; sample miso into the LSB of the rx shift register.
  - On ref_fall: spi_clk_o=0.
    - If bitcnt<DATA_W-1: shift left, drive the next bit on mosi, bitcnt++.
    - Else (byte complete): copy rx into rx_last (internal, not exported).
    - Then, if FIFO not empty: pop the next byte, drive its MSB, bitcnt=0, stay in SHIFT with ss held low, so back-to-back bytes have no ss gap.
    - If FIFO empty: ss=1, mosi=0, go to IDLE.
- Timing guarantees:
  - mosi changes only on SCK falling edges (or at ss assertion).
  - mosi is stable during the whole SCK-high phase.
  - Exactly DATA_W SCK pulses per byte.
- Latency:
  - First SCK rising edge follows the first ref_fall after the push, then the next ref_rise (about 1 ref period plus 3 clk for sync and edge detect).
- Simultaneous events:
  - A push into an empty FIFO on the same cycle as ref_fall in IDLE is not seen until the next ref_fall.
  - Writes during an active transfer append to the queue and do not disturb the byte in flight.
- `value` is sampled only on cycles where interrupt=1; it is don't-care otherwise.

Decomposition:
- Shared package spi_pkg:
  - DATA_W default.
  - State enum {IDLE, SHIFT}.
- One sub-module, spi_tx_fifo: synchronous FIFO with parameters DATA_W and FIFO_DEPTH; ports clk, rst_n, push, din, pop, dout, full, empty; show-ahead read.
- The synchronizer, edge detector and shift FSM stay in the top module.

Test Plan:
- Burst write on 4 consecutive clk cycles of 0x2A, 0xFF, 0x40, 0x21 (interrupt high 4 cycles), spi_clk = clk/3:
  - ss low for one contiguous window of 32 SCK pulses.
  - mosi sampled on SCK rising edges gives 00101010 11111111 01000000 00100001.
  - ss returns high after the last falling edge; spi_clk_o low when idle.
- Single write 0xA5 with miso tied to mosi (loopback):
  - 8 SCK pulses, mosi = 10100101.
  - Internal rx_last = 0xA5; ss high afterwards.
- Overflow: 10 consecutive writes 0x01..0x0A while idle (FIFO_DEPTH=8):
  - Only 0x01..0x08 transmitted, in order.
  - 0x09 and 0x0A dropped.
- Append while busy: write 0x3C, then write 0xC3 during bit 3 of the first byte:
  - Both bytes sent back-to-back under one ss-low window, 16 SCK pulses.
- Reset mid-transfer: assert rst_n=0 during bit 4 of 0xF0 with 2 bytes queued:
  - ss=1, spi_clk_o=0, mosi=0 asynchronously.
  - After release with no new writes, no SCK activity.
- Idle: no writes for 200 clk:
  - ss=1, spi_clk_o=0, mosi=0 throughout, regardless of spi_clk toggling.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit controller slice.
//   SPI_DATA_W  : default SPI word width
//   spi_state_e : shift FSM state encoding
package spi_pkg;

    localparam int unsigned SPI_DATA_W = 8;

    typedef enum logic {
        IDLE,
        SHIFT
    } spi_state_e;

endpackage

// File: rtl/spi_tx_controller_if.sv
// Write-strobe bus feeding the SPI transmit controller.
//   interrupt : write strobe, one byte pushed per clk with interrupt=1
//   value     : byte to queue, sampled only while interrupt=1
// Modports: master drives the bus (CPU side), slave receives it (controller).
interface spi_tx_controller_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W
) ();

    logic              interrupt;
    logic [DATA_W-1:0] value;

    modport master (output interrupt, output value);
    modport slave  (input  interrupt, input  value);

endinterface

// File: rtl/spi_tx_fifo.sv
// Synchronous show-ahead FIFO holding bytes waiting for transmission.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data; dropped while full
//   pop, dout  : read request; dout always presents the head entry
//   full, empty: occupancy flags
module spi_tx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_tx_controller.sv
// Byte-oriented SPI master transmitter, mode 0, MSB first.
// Bytes written over the strobe bus are queued and streamed back-to-back
// under a single ss-low window while the queue stays non-empty.
//   clk, rst_n : system clock, asynchronous active-low reset
//   spi_clk    : SCK reference (asynchronous, <= clk/3), sets the bit rate
//   bus        : write strobe bus (interrupt, value)
//   miso       : serial data from the slave, sampled on SCK rising edges
//   mosi       : serial data to the slave, changes on SCK falling edges
//   ss         : slave select, active low
//   spi_clk_o  : SCK to the slave, idles low
module spi_tx_controller
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W     = SPI_DATA_W,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_clk,
    spi_tx_controller_if.slave    bus,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  ss,
    output logic                  spi_clk_o
);

    localparam int unsigned        CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0]      LAST = CW'(DATA_W - 1);

    spi_state_e        state_q;
    spi_state_e        state_d;

    logic              ref_meta;
    logic              ref_s;
    logic              ref_d;
    logic              ref_rise;
    logic              ref_fall;

    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    logic              load;
    logic              shift_en;
    logic              byte_done;

    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] rx_last;
    logic [CW-1:0]     bitcnt_q;
    logic              sck_q;

    spi_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.interrupt),
        .din   (bus.value),
        .pop   (load),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // 2-FF synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_meta <= 1'b0;
            ref_s    <= 1'b0;
            ref_d    <= 1'b0;
        end else begin
            ref_meta <= spi_clk;
            ref_s    <= ref_meta;
            ref_d    <= ref_s;
        end
    end

    assign ref_rise = ref_s && !ref_d;
    assign ref_fall = !ref_s && ref_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode. Empty is registered, so a push landing
    // on the same cycle as ref_fall in IDLE waits for the next ref_fall.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (ref_fall && !fifo_empty) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ref_fall) begin
                    if (bitcnt_q != LAST) begin
                        shift_en = 1'b1;
                    end else begin
                        byte_done = 1'b1;
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs. ss and mosi follow the state register directly so an
    // asynchronous reset forces them to idle values immediately.
    always_comb begin
        ss        = (state_q != SHIFT);
        mosi      = (state_q == SHIFT) ? sh_q[DATA_W-1] : 1'b0;
        spi_clk_o = sck_q;
    end

    // Shift datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q     <= '0;
            rx_q     <= '0;
            rx_last  <= '0;
            bitcnt_q <= '0;
            sck_q    <= 1'b0;
        end else begin
            if (load) begin
                sh_q     <= fifo_dout;
                bitcnt_q <= '0;
            end else if (shift_en) begin
                sh_q     <= sh_q << 1;
                bitcnt_q <= bitcnt_q + 1'b1;
            end

            if (state_q == SHIFT) begin
                if (ref_rise) begin
                    sck_q <= 1'b1;
                    rx_q  <= {rx_q[DATA_W-2:0], miso};
                end else if (ref_fall) begin
                    sck_q <= 1'b0;
                end
            end else begin
                sck_q <= 1'b0;
            end

            if (byte_done) begin
                rx_last <= rx_q;
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_controller.sv
// Directed self-checking bench for spi_tx_controller.
module tb_spi_tx_controller;
    import spi_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic spi_clk = 1'b0;
    logic ref_en  = 1'b1;
    logic loop_en = 1'b0;
    logic miso;
    logic mosi;
    logic ss;
    logic spi_clk_o;

    int tests_run    = 0;
    int tests_failed = 0;

    spi_tx_controller_if #(.DATA_W(DW)) bus ();

    spi_tx_controller #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .bus       (bus.slave),
        .miso      (miso),
        .mosi      (mosi),
        .ss        (ss),
        .spi_clk_o (spi_clk_o)
    );

    assign miso = loop_en ? mosi : 1'b0;

    always #5 clk = ~clk;
    // spi_clk = clk/3 while enabled, parked low otherwise.
    always #15 spi_clk = ref_en ? ~spi_clk : 1'b0;

    // Line monitor: counters only ever grow; tests take deltas.
    int   pulses      = 0;
    int   windows     = 0;
    int   unstable    = 0;
    int   sck_outside = 0;
    int   idle_mosi   = 0;
    logic bits[$];
    logic prev_sck    = 1'b0;
    logic prev_ss     = 1'b1;

    always @(negedge clk) begin
        if (spi_clk_o && !prev_sck) begin
            pulses++;
            bits.push_back(mosi);
        end
        if (spi_clk_o && prev_sck && bits.size() > 0) begin
            if (mosi !== bits[$]) unstable++;
        end
        if (prev_ss && !ss) windows++;
        if (spi_clk_o && ss) sck_outside++;
        if (ss && mosi) idle_mosi++;
        prev_sck = spi_clk_o;
        prev_ss  = ss;
    end

    int p0, w0, u0, o0, i0;

    task automatic snap();
        p0 = pulses;
        w0 = windows;
        u0 = unstable;
        o0 = sck_outside;
        i0 = idle_mosi;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] v);
        @(negedge clk);
        bus.interrupt = 1'b1;
        bus.value     = v;
    endtask

    task automatic end_write();
        @(negedge clk);
        bus.interrupt = 1'b0;
        bus.value     = '0;
    endtask

    function automatic logic [7:0] byte_at(input int base, input int k);
        logic [7:0] r;
        r = 'x;
        for (int i = 0; i < 8; i++) begin
            if (base + 8 * k + i < bits.size())
                r = {r[6:0], bits[base + 8 * k + i]};
            else
                r = {r[6:0], 1'bx};
        end
        return r;
    endfunction

    // Bounded wait for ss low then ss high again.
    task automatic wait_transfer(input string tag);
        int n;
        n = 0;
        while (ss && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, 32'(n < 2000), 32'd1);
        n = 0;
        while (!ss && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_end"}, 32'(n < 4000), 32'd1);
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_pulses(input string tag, input int target);
        int n;
        n = 0;
        while ((pulses - p0) < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reach"}, 32'(n < 2000), 32'd1);
    endtask

    task automatic park_ref();
        ref_en = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    logic [7:0] burst_exp [4];
    logic [7:0] app_exp [2];

    initial begin
        bus.interrupt = 1'b0;
        bus.value     = '0;
        burst_exp = '{8'h2A, 8'hFF, 8'h40, 8'h21};
        app_exp   = '{8'h3C, 8'hC3};

        // Reset values
        #1;
        check("rst_ss", 32'(ss), 32'd1);
        check("rst_sck", 32'(spi_clk_o), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Burst of four bytes on consecutive cycles
        snap();
        write_byte(8'h2A);
        write_byte(8'hFF);
        write_byte(8'h40);
        write_byte(8'h21);
        end_write();
        wait_transfer("burst");
        check("burst_pulses", 32'(pulses - p0), 32'd32);
        check("burst_windows", 32'(windows - w0), 32'd1);
        for (int k = 0; k < 4; k++)
            check($sformatf("burst_byte%0d", k), 32'(byte_at(p0, k)), 32'(burst_exp[k]));
        check("burst_stable", 32'(unstable - u0), 32'd0);
        check("burst_sck_out", 32'(sck_outside - o0), 32'd0);
        check("burst_idle_sck", 32'(spi_clk_o), 32'd0);
        check("burst_idle_ss", 32'(ss), 32'd1);

        // Loopback single byte
        loop_en = 1'b1;
        snap();
        write_byte(8'hA5);
        end_write();
        wait_transfer("loop");
        check("loop_pulses", 32'(pulses - p0), 32'd8);
        check("loop_byte", 32'(byte_at(p0, 0)), 32'hA5);
        check("loop_rx_last", 32'(dut.rx_last), 32'hA5);
        check("loop_ss", 32'(ss), 32'd1);
        loop_en = 1'b0;

        // Overflow: ten writes with the reference parked
        park_ref();
        snap();
        for (int v = 1; v <= 10; v++) write_byte(8'(v));
        end_write();
        ref_en = 1'b1;
        wait_transfer("ovf");
        check("ovf_pulses", 32'(pulses - p0), 32'd64);
        check("ovf_windows", 32'(windows - w0), 32'd1);
        for (int k = 0; k < 8; k++)
            check($sformatf("ovf_byte%0d", k), 32'(byte_at(p0, k)), 32'(k + 1));

        // Append while busy
        snap();
        write_byte(8'h3C);
        end_write();
        wait_pulses("app", 4);
        write_byte(8'hC3);
        end_write();
        wait_transfer("app");
        check("app_pulses", 32'(pulses - p0), 32'd16);
        check("app_windows", 32'(windows - w0), 32'd1);
        for (int k = 0; k < 2; k++)
            check($sformatf("app_byte%0d", k), 32'(byte_at(p0, k)), 32'(app_exp[k]));
        check("app_stable", 32'(unstable - u0), 32'd0);

        // Reset mid-transfer with two bytes queued
        park_ref();
        snap();
        write_byte(8'hF0);
        write_byte(8'h11);
        write_byte(8'h22);
        end_write();
        ref_en = 1'b1;
        wait_pulses("mrst", 5);
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_ss", 32'(ss), 32'd1);
        check("mrst_sck", 32'(spi_clk_o), 32'd0);
        check("mrst_mosi", 32'(mosi), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap();
        repeat (200) @(negedge clk);
        check("mrst_after_pulses", 32'(pulses - p0), 32'd0);
        check("mrst_after_windows", 32'(windows - w0), 32'd0);
        check("mrst_after_ss", 32'(ss), 32'd1);

        // Idle with the reference toggling
        snap();
        repeat (200) @(negedge clk);
        check("idle_pulses", 32'(pulses - p0), 32'd0);
        check("idle_windows", 32'(windows - w0), 32'd0);
        check("idle_sck_out", 32'(sck_outside - o0), 32'd0);
        check("idle_mosi", 32'(idle_mosi - i0), 32'd0);
        check("idle_ss", 32'(ss), 32'd1);
        check("idle_sck", 32'(spi_clk_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
